// File: rtl/sw_debounce_pkg.sv
// Board-level constants and sizing helpers shared by the switch debouncer.
package sw_debounce_pkg;
  localparam int CLK_HZ         = 16_000_000;
  localparam int DEFAULT_DIV    = CLK_HZ / 1000;
  localparam int DEFAULT_STABLE = 4;

  // Counter width for a modulus n, never below one bit so DIV=1 still builds.
  function automatic int cnt_w(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction
endpackage

// File: rtl/sw_debounce_bit.sv
// One switch bit: 2-FF synchroniser, tick-sampled stability counter,
// debounced state and registered rise/fall strobes.
module deb_bit
  import sw_debounce_pkg::*;
#(
  parameter int STABLE = DEFAULT_STABLE
) (
  input  logic clk,
  input  logic rst,
  input  logic i_tick,
  input  logic i_raw,
  output logic o_sw,
  output logic o_rise,
  output logic o_fall,
  output logic o_acc
);
  localparam int SCW = $clog2(STABLE + 1);

  logic           r_meta;
  logic           r_sync;
  logic [SCW-1:0] r_scnt;
  logic           r_sw;
  logic           r_rise;
  logic           r_fall;
  logic           w_diff;
  logic           w_full;

  assign w_diff = r_sync ^ r_sw;
  assign w_full = (r_scnt >= SCW'(STABLE - 1));
  // Change accepted on this edge; the top registers the OR of these as chg.
  assign o_acc  = i_tick & w_diff & w_full;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_meta <= 1'b0;
      r_sync <= 1'b0;
      r_scnt <= '0;
      r_sw   <= 1'b0;
      r_rise <= 1'b0;
      r_fall <= 1'b0;
    end else begin
      r_meta <= i_raw;
      r_sync <= r_meta;
      r_rise <= 1'b0;
      r_fall <= 1'b0;
      if (i_tick) begin
        if (!w_diff) begin
          r_scnt <= '0;
        end else if (w_full) begin
          r_sw   <= ~r_sw;
          r_scnt <= '0;
          r_rise <= ~r_sw;
          r_fall <= r_sw;
        end else begin
          r_scnt <= r_scnt + SCW'(1);
        end
      end
    end
  end

  assign o_sw   = r_sw;
  assign o_rise = r_rise;
  assign o_fall = r_fall;
endmodule

// File: rtl/sw_debounce.sv
// Debounces WIDTH raw switch pins; one shared sample-tick prescaler drives
// WIDTH independent deb_bit slices.
module sw_debounce
  import sw_debounce_pkg::*;
#(
  parameter int WIDTH  = 8,
  parameter int DIV    = DEFAULT_DIV,
  parameter int STABLE = DEFAULT_STABLE
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] sw_raw,
  output logic [WIDTH-1:0] sw,
  output logic [WIDTH-1:0] rise,
  output logic [WIDTH-1:0] fall,
  output logic             chg
);
  localparam int PW = cnt_w(DIV);

  logic [PW-1:0]    r_cnt;
  logic             r_chg;
  logic             w_tick;
  logic [WIDTH-1:0] w_acc;

  assign w_tick = (r_cnt == PW'(DIV - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt <= '0;
      r_chg <= 1'b0;
    end else begin
      r_cnt <= w_tick ? '0 : r_cnt + PW'(1);
      r_chg <= |w_acc;
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < WIDTH; gi++) begin : g_bit
      deb_bit #(
        .STABLE(STABLE)
      ) u_bit (
        .clk   (clk),
        .rst   (rst),
        .i_tick(w_tick),
        .i_raw (sw_raw[gi]),
        .o_sw  (sw[gi]),
        .o_rise(rise[gi]),
        .o_fall(fall[gi]),
        .o_acc (w_acc[gi])
      );
    end
  endgenerate

  assign chg = r_chg;
endmodule
